// File: rtl/pc_fetch.sv
// Instruction-fetch stage: holds the fetch PC, requests words over req/ack and feeds decode.
// Redirects from EX squash the fetch buffer and any in-flight fetch; the delay slot survives.
module pc_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] EXC_VECTOR   = 32'h80000180
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [4:0]  PCsel,
    input  logic [31:0] PCoffset,
    input  logic [25:0] PCjump,
    input  logic [31:0] RegTarget,
    input  logic        EXvalid,
    input  logic        Stall,
    output logic        IReq,
    output logic [31:0] IAddr,
    input  logic        IAck,
    input  logic [31:0] IData,
    output logic [31:0] I1,
    output logic [31:0] PC1,
    output logic        V1,
    output logic [31:0] PC2
);

    typedef enum logic [1:0] {StIdle, StReq, StKill, StFull} state_e;

    state_e      state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] kaddr_q, kaddr_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] i1_q, i1_d;
    logic [31:0] pc1_q, pc1_d;
    logic        v1_q, v1_d;
    logic [31:0] pc2_q, pc2_d;

    logic        advance;
    logic        sel_onehot;
    logic        redirect;
    logic [31:0] p4;
    logic [31:0] target;
    logic [31:0] req_addr;
    logic        unused_bits;

    assign unused_bits = ^RegTarget[1:0];

    assign advance    = !Stall;
    assign sel_onehot = (PCsel != 5'd0) && ((PCsel & (PCsel - 5'd1)) == 5'd0);
    // Non-one-hot selects fall back to sequential fetch.
    assign redirect   = advance && EXvalid && sel_onehot && !PCsel[0];
    assign p4         = pc2_q + 32'd4;

    always_comb begin
        target = EXC_VECTOR;
        unique case (PCsel)
            5'b00010: target = p4 + PCoffset;
            5'b00100: target = {p4[31:28], PCjump, 2'b00};
            5'b01000: target = {RegTarget[31:2], 2'b00};
            default:  target = EXC_VECTOR;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pcf_d       = pcf_q;
        kaddr_d     = kaddr_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        i1_d        = i1_q;
        pc1_d       = pc1_q;
        v1_d        = v1_q;
        pc2_d       = pc2_q;
        IReq        = 1'b0;
        req_addr    = pcf_q;

        // Bubble by default; overwritten below when a word is available.
        if (advance) begin
            pc2_d = pc1_q;
            v1_d  = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                state_d = StReq;
                if (redirect) pcf_d = target;
            end
            StReq: begin
                IReq     = 1'b1;
                req_addr = pcf_q;
                if (redirect) begin
                    pcf_d = target;
                    if (!IAck) begin
                        kaddr_d = pcf_q;
                        state_d = StKill;
                    end
                end else if (IAck) begin
                    pcf_d = pcf_q + 32'd4;
                    if (advance) begin
                        i1_d  = IData;
                        pc1_d = pcf_q;
                        v1_d  = 1'b1;
                    end else begin
                        buf_instr_d = IData;
                        buf_pc_d    = pcf_q;
                        state_d     = StFull;
                    end
                end
            end
            StKill: begin
                // Old request must complete before a new address may be presented.
                IReq     = 1'b1;
                req_addr = kaddr_q;
                if (redirect) pcf_d = target;
                if (IAck) state_d = StReq;
            end
            StFull: begin
                if (redirect) begin
                    pcf_d   = target;
                    state_d = StReq;
                end else if (advance) begin
                    i1_d    = buf_instr_q;
                    pc1_d   = buf_pc_q;
                    v1_d    = 1'b1;
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign IAddr = {req_addr[31:2], 2'b00};
    assign I1    = i1_q;
    assign PC1   = pc1_q;
    assign V1    = v1_q;
    assign PC2   = pc2_q;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q     <= StIdle;
            pcf_q       <= RESET_VECTOR;
            kaddr_q     <= RESET_VECTOR;
            buf_instr_q <= 32'd0;
            buf_pc_q    <= 32'd0;
            i1_q        <= 32'd0;
            pc1_q       <= 32'd0;
            v1_q        <= 1'b0;
            pc2_q       <= 32'd0;
        end else begin
            state_q     <= state_d;
            pcf_q       <= pcf_d;
            kaddr_q     <= kaddr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            i1_q        <= i1_d;
            pc1_q       <= pc1_d;
            v1_q        <= v1_d;
            pc2_q       <= pc2_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: expected decode PCs are queued as stimulus is applied
// and popped whenever a new valid instruction reaches I1.
module tb_pc_fetch;

    logic        CLK;
    logic        RESET_N;
    logic [4:0]  PCsel;
    logic [31:0] PCoffset;
    logic [25:0] PCjump;
    logic [31:0] RegTarget;
    logic        EXvalid;
    logic        Stall;
    logic        IReq;
    logic [31:0] IAddr;
    logic        IAck;
    logic [31:0] IData;
    logic [31:0] I1;
    logic [31:0] PC1;
    logic        V1;
    logic [31:0] PC2;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    pc_fetch dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .PCsel    (PCsel),
        .PCoffset (PCoffset),
        .PCjump   (PCjump),
        .RegTarget(RegTarget),
        .EXvalid  (EXvalid),
        .Stall    (Stall),
        .IReq     (IReq),
        .IAddr    (IAddr),
        .IAck     (IAck),
        .IData    (IData),
        .I1       (I1),
        .PC1      (PC1),
        .V1       (V1),
        .PC2      (PC2)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5AC3C3;
    endfunction

    assign IData = mem(IAddr);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; a new I1 entry is one that was loaded by an advancing edge out of reset.
    task automatic tick();
        logic adv;
        logic rst;
        logic [31:0] e;
        adv = !Stall;
        rst = RESET_N;
        @(posedge CLK);
        #1;
        if (rst && adv && V1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_extra observed PC1 %h expected none", PC1);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", PC1, e);
                check("sb_instr", I1, mem(e));
            end
        end
    endtask

    task automatic ex(input logic [4:0] sel);
        EXvalid = 1'b1;
        PCsel   = sel;
    endtask

    task automatic ex_clear();
        EXvalid = 1'b0;
        PCsel   = 5'b00001;
    endtask

    initial begin
        RESET_N   = 1'b0;
        IAck      = 1'b1;
        Stall     = 1'b0;
        PCoffset  = 32'd0;
        PCjump    = 26'd0;
        RegTarget = 32'd0;
        ex_clear();
        tick();
        tick();
        check("rst_ireq", {31'd0, IReq}, 32'd0);
        check("rst_v1", {31'd0, V1}, 32'd0);
        check("rst_i1", I1, 32'd0);
        check("rst_pc1", PC1, 32'd0);
        check("rst_pc2", PC2, 32'd0);

        // Sequential fetch with zero-wait memory.
        RESET_N = 1'b1;
        exp_q.push_back(32'hBFC00000);
        exp_q.push_back(32'hBFC00004);
        tick();
        check("seq0_ireq", {31'd0, IReq}, 32'd1);
        check("seq0_addr", IAddr, 32'hBFC00000);
        tick();
        check("seq1_addr", IAddr, 32'hBFC00004);
        tick();
        check("seq2_addr", IAddr, 32'hBFC00008);

        // JR with unaligned register value.
        RegTarget = 32'h80001003;
        ex(5'b01000);
        exp_q.push_back(32'h80001000);
        exp_q.push_back(32'h80001004);
        tick();
        ex_clear();
        check("jr_addr", IAddr, 32'h80001000);
        check("jr_v1", {31'd0, V1}, 32'd0);
        tick();
        tick();

        // Move to 0x100, then BEQ from PC2=0x100.
        RegTarget = 32'h00000100;
        ex(5'b01000);
        exp_q.push_back(32'h00000100);
        exp_q.push_back(32'h00000104);
        tick();
        ex_clear();
        check("jr2_addr", IAddr, 32'h00000100);
        tick();
        tick();
        check("beq_pc2", PC2, 32'h00000100);
        check("beq_pc1", PC1, 32'h00000104);
        PCoffset = 32'h00000020;
        ex(5'b00010);
        exp_q.push_back(32'h00000124);
        tick();
        ex_clear();
        check("beq_addr", IAddr, 32'h00000124);
        check("beq_slot_pc2", PC2, 32'h00000104);
        check("beq_v1", {31'd0, V1}, 32'd0);
        tick();

        // J from PC2=0xBFC00010.
        RegTarget = 32'hBFC00010;
        ex(5'b01000);
        exp_q.push_back(32'hBFC00010);
        exp_q.push_back(32'hBFC00014);
        tick();
        ex_clear();
        check("jr3_addr", IAddr, 32'hBFC00010);
        tick();
        tick();
        check("j_pc2", PC2, 32'hBFC00010);
        PCjump = 26'h0000040;
        ex(5'b00100);
        tick();
        ex_clear();
        check("j_addr", IAddr, 32'hB0000100);

        // Vector redirect while the request is outstanding.
        IAck = 1'b0;
        tick();
        check("wait_addr", IAddr, 32'hB0000100);
        ex(5'b10000);
        tick();
        ex_clear();
        check("kill_ireq", {31'd0, IReq}, 32'd1);
        check("kill_addr", IAddr, 32'hB0000100);
        tick();
        check("kill_addr2", IAddr, 32'hB0000100);
        IAck = 1'b1;
        exp_q.push_back(32'h80000180);
        exp_q.push_back(32'h80000184);
        exp_q.push_back(32'h80000188);
        exp_q.push_back(32'h8000018C);
        tick();
        check("vec_addr", IAddr, 32'h80000180);
        check("vec_ireq", {31'd0, IReq}, 32'd1);
        check("vec_v1", {31'd0, V1}, 32'd0);
        tick();
        tick();

        // Stall with a returned word parked in the buffer.
        Stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_ireq", {31'd0, IReq}, 32'd0);
            check("stall_pc1", PC1, 32'h80000184);
            check("stall_i1", I1, mem(32'h80000184));
            check("stall_pc2", PC2, 32'h80000180);
        end
        Stall = 1'b0;
        tick();
        check("rel_addr", IAddr, 32'h8000018C);
        check("rel_pc2", PC2, 32'h80000184);
        tick();

        // Reset mid-REQ.
        RESET_N = 1'b0;
        tick();
        check("mr_ireq", {31'd0, IReq}, 32'd0);
        check("mr_v1", {31'd0, V1}, 32'd0);
        check("mr_pc1", PC1, 32'd0);
        check("mr_pc2", PC2, 32'd0);
        RESET_N = 1'b1;
        tick();
        check("mr_restart", IAddr, 32'hBFC00000);

        // Reset mid-FULL.
        Stall = 1'b1;
        tick();
        check("mf_full_ireq", {31'd0, IReq}, 32'd0);
        RESET_N = 1'b0;
        Stall   = 1'b0;
        tick();
        check("mf_ireq", {31'd0, IReq}, 32'd0);
        check("mf_v1", {31'd0, V1}, 32'd0);
        RESET_N = 1'b1;
        exp_q.push_back(32'hBFC00000);
        exp_q.push_back(32'hBFC00004);
        exp_q.push_back(32'hBFC00008);
        tick();
        check("mf_restart", IAddr, 32'hBFC00000);
        tick();

        // Non-one-hot select behaves as sequential.
        ex(5'b00110);
        tick();
        ex_clear();
        check("nonhot_addr", IAddr, 32'hBFC00008);
        tick();
        check("sb_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Instruction-fetch stage directly upstream of ifcontr.
- Holds the fetch PC, issues word requests to instruction memory over a req/ack handshake, and delivers instruction/PC pairs to decode (I1/PC1).
- Tracks the PC of the instruction in EX (PC2).
- Consumes PCsel/PCoffset/PCjump from ifcontr plus the register target to form the next PC, squashing wrong-path fetches after a redirect.

Parameters:
RESET_VECTOR, 32'hBFC00000, PC loaded on reset
EXC_VECTOR, 32'h80000180, target when PCsel selects the exception vector

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET_N  input  1  synchronous, active-low reset
PCsel  input  5  one-hot next-PC select from ifcontr: bit0 inc, bit1 add, bit2 jump, bit3 register, bit4 vector
PCoffset  input  32  branch offset, already sign-extended and shifted
PCjump  input  26  jump target field
RegTarget  input  32  rs value for JR/JALR
EXvalid  input  1  instruction in EX is valid; PCsel is ignored when 0
Stall  input  1  hazard freeze of the decode/EX registers
IReq  output  1  instruction memory request
IAddr  output  32  request word address, bits [1:0] always 0
IAck  input  1  memory response valid, may arrive in the same cycle as IReq
IData  input  32  instruction word, valid with IAck
I1  output  32  instruction to decode
PC1  output  32  PC of I1
V1  output  1  I1 valid
PC2  output  32  PC of the instruction in EX

Behaviour:
- Reset (RESET_N=0 at edge):
  - PCF=RESET_VECTOR, IReq=0, I1=0, PC1=0, V1=0, PC2=0.
  - Fetch buffer empty, state=IDLE.
  - Reset overrides every other input, including mid-request; a pending IAck is ignored.
- advance = !Stall. When advance: PC2<=PC1; {I1,PC1,V1} <= next decode entry.
- Redirect = advance & EXvalid & !PCsel[0]. Target, with P4=PC2+4:
  - add: P4+PCoffset (32-bit wrap).
  - jump: {P4[31:28],PCjump,2'b00}.
  - register: {RegTarget[31:2],2'b00}.
  - vector: EXC_VECTOR.
  - Non-one-hot PCsel: treated as inc (no redirect).
- Delay slot: the instruction in I1 at redirect time is kept. The fetch buffer and any in-flight/returning fetch are squashed.
- FSM states:
  - IDLE: IReq=0. Next cycle -> REQ with IAddr=PCF.
  - REQ: IReq=1, IAddr=PCF held stable until IAck.
    - On IAck without redirect: PCF<=PCF+4.
    - If advance, the word goes to I1 (V1=1), a new request for PCF+4 issues next cycle, and the state stays REQ.
    - If stalled, the word goes to the fetch buffer -> FULL.
    - On redirect with no IAck: -> KILL, PCF<=target.
    - On redirect with IAck the same cycle: the word is discarded, PCF<=target, stay REQ (new address next cycle).
  - KILL: IReq=1 at the old address, held until IAck. The acked word is discarded; next cycle -> REQ at PCF.
  - FULL: IReq=0. On advance the buffer moves to I1 and the state -> REQ. On redirect the buffer is cleared, PCF<=target, -> REQ.
- V1 update on advance with no instruction available: V1<=0 (bubble). I1/PC1 hold their values while Stall=1.
- Stall and redirect are mutually exclusive by definition: redirect requires advance.
- Memory-to-decode latency: minimum 1 cycle from IAck to I1. Steady-state throughput: 1 instruction/cycle with zero-wait memory.

Test Plan:
- Reset release, IAck always 1 -> IAddr sequence BFC00000, BFC00004, BFC00008. V1 first 1 one cycle after the first IAck; PC1 tracks IAddr by one cycle.
- BEQ in EX with PC2=0x100, PCoffset=0x20, PCsel=add, EXvalid=1 -> next IAddr=0x124. I1 delay slot (PC1=0x104) kept. The word returned for 0x108 dropped; the next V1 instruction has PC1=0x124.
- J with PC2=0xBFC00010, PCjump=0x0000040 -> IAddr=0xB0000100. JR with RegTarget=0x80001003 -> IAddr=0x80001000.
- Redirect while a request is outstanding (IAck delayed 3 cycles) -> IAddr stays at the old address until IAck; that word never appears in I1; the next request uses the target.
- Stall high 4 cycles with a returned word -> IReq=0 in FULL; I1/PC1/PC2 frozen. After release, the buffered word appears in I1 next cycle and no fetch is lost or duplicated.
- RESET_N low mid-REQ and mid-FULL -> next cycle PCF=BFC00000, V1=0, IReq=0; then fetch restarts at BFC00000. PCsel=vector -> IAddr=0x80000180.
